ram_access_ctrl: RTL

Initiator-side master for the four_by_four_ram array port (sel/rw/data). Accepts host requests on a valid/ready handshake, drives registered RAM control, and returns read data on a valid/ready response channel. After reset it walks every RAM word and writes INIT_VAL, so the array starts from a known state. It sits between host logic and the RAM and replaces ad-hoc direct driving of sel/rw/data.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/four_by_four_ram.sv | 43 ++++
 rtl/ram_access_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the four_by_four_ram access path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ram_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;

  // RAM rw_i convention: high reads, low writes.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

endpackage

// File: rtl/four_by_four_ram.sv
// Small word-addressed RAM with a registered, fixed-latency read port.
// Latency: write commits at the edge that ends the rw_i=0 cycle; read data
//   appears RD_LAT edges after sel_i is presented. Backpressure: none.
// Ports: clk_i, rst_i (active-high, clears the read pipe only), sel_i word
//   select, rw_i (1 read / 0 write), data_i write data, data_o read data.
`timescale 1ns/1ps
module four_by_four_ram
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] sel_i,
  input  logic              rw_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] r_mem  [2**ADDR_W];
  logic [DATA_W-1:0] r_pipe [RD_LAT];

  // Array contents survive reset; only the controller's sweep clears them.
  always_ff @(posedge clk_i) begin
    if (rw_i == RW_WRITE) begin
      r_mem[sel_i] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= r_mem[sel_i];
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign data_o = r_pipe[RD_LAT-1];

endmodule

// File: rtl/ram_access_ctrl.sv
// Host-side master for the four_by_four_ram sel/rw/data port, with a post-reset clear sweep.
// Latency: write drives the RAM the cycle after accept; read response is valid RD_LAT+1 edges after accept.
// Backpressure: one request at a time; req_ready_o drops until a write issues or a read response is taken.
// Ports: Clk, rst_ni (async active-low, release expected to be synchronous upstream);
//   req_* host request (valid/ready, rw 1=read, sel, data); rsp_* read response (valid/ready, data);
//   init_done_o sticky sweep-finished flag; ram_sel_o/ram_rw_o/ram_data_o to the RAM, ram_data_i from it.
`timescale 1ns/1ps
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int                ADDR_W         = ADDR_W_DEF,
  parameter int                DATA_W         = DATA_W_DEF,
  parameter int                RD_LAT         = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
  input  logic              Clk,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_rw_i,
  input  logic [ADDR_W-1:0] req_sel_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              init_done_o,
  output logic [ADDR_W-1:0] ram_sel_o,
  output logic              ram_rw_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      LAT_LD    = 2'(RD_LAT);
  localparam state_t          RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_init_cnt, w_init_cnt_nxt;
  logic [1:0]        r_lat_cnt, w_lat_cnt_nxt;
  logic [ADDR_W-1:0] w_ram_sel_nxt;
  logic              w_ram_rw_nxt;
  logic [DATA_W-1:0] w_ram_data_nxt;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rsp_data_nxt;
  logic              w_init_done_nxt;
  logic              w_accept;

  assign req_ready_o = (r_state == ST_IDLE);
  assign w_accept    = req_valid_i && req_ready_o;

  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_lat_cnt_nxt   = r_lat_cnt;
    w_ram_sel_nxt   = ram_sel_o;
    w_ram_rw_nxt    = RW_READ;
    w_ram_data_nxt  = ram_data_o;
    w_rsp_valid_nxt = rsp_valid_o;
    w_rsp_data_nxt  = rsp_data_o;
    w_init_done_nxt = init_done_o;

    case (r_state)
      ST_INIT: begin
        // Counter runs one past the last word so the final write gets its
        // full cycle before the FSM releases the port.
        if (r_init_cnt == LAST_CNT) begin
          w_state_nxt     = ST_IDLE;
          w_init_done_nxt = 1'b1;
        end else begin
          w_ram_sel_nxt  = r_init_cnt[ADDR_W-1:0];
          w_ram_rw_nxt   = RW_WRITE;
          w_ram_data_nxt = INIT_VAL;
          w_init_cnt_nxt = r_init_cnt + (ADDR_W+1)'(1);
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_ram_sel_nxt = req_sel_i;
          if (req_rw_i == RW_WRITE) begin
            w_state_nxt    = ST_WRITE;
            w_ram_rw_nxt   = RW_WRITE;
            w_ram_data_nxt = req_data_i;
          end else begin
            w_state_nxt   = ST_READ;
            w_lat_cnt_nxt = LAT_LD;
          end
        end
      end
      // RAM commits at the end of this cycle; rw falls back to read by default.
      ST_WRITE: w_state_nxt = ST_IDLE;
      // First READ cycle presents the command; RD_LAT more cycles cover the
      // RAM pipe, and the last one samples its output.
      ST_READ: begin
        if (r_lat_cnt == 2'd0) begin
          w_rsp_data_nxt  = ram_data_i;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= RST_STATE;
      r_init_cnt  <= '0;
      r_lat_cnt   <= '0;
      ram_sel_o   <= '0;
      ram_rw_o    <= RW_READ;
      ram_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      init_done_o <= !CLEAR_ON_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      ram_sel_o   <= w_ram_sel_nxt;
      ram_rw_o    <= w_ram_rw_nxt;
      ram_data_o  <= w_ram_data_nxt;
      rsp_valid_o <= w_rsp_valid_nxt;
      rsp_data_o  <= w_rsp_data_nxt;
      init_done_o <= w_init_done_nxt;
    end
  end

endmodule
